// File: rtl/a2_a2_pkg.sv
// Shared types for the a2_a2 registered 2-bit adder slice.
// The operand width is fixed at 2; the result type carries the extra carry bit.
package a2_a2_pkg;

    localparam int A2_A2_WIDTH = 2;

    typedef logic [A2_A2_WIDTH-1:0] a2_a2_opnd_t;
    typedef logic [A2_A2_WIDTH:0]   a2_a2_res_t;

endpackage : a2_a2_pkg

// File: rtl/a2_a2_fa.sv
// Single-bit full adder cell.
// This cell is purely combinational and is chained to form the ripple core of a2_a2.
module a2_a2_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : a2_a2_fa

// File: rtl/a2_a2.sv
// Registered 2-bit ripple adder with carry-in: {c, s} = x + y + c0, latency 1.
// Define A2_A2_INREG_EN to add an input register stage (latency 2).
module a2_a2
    import a2_a2_pkg::*;
#(
    parameter int WIDTH = A2_A2_WIDTH
) (
    output logic [WIDTH-1:0] s,
    output logic             c,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c0,
    input  logic             clk,
    input  logic             rst_n
);

    generate
        if (WIDTH != A2_A2_WIDTH) begin : g_bad_width
            $error("a2_a2: WIDTH must be 2");
        end
    endgenerate

    a2_a2_opnd_t op_a;
    a2_a2_opnd_t op_b;
    logic        op_ci;

`ifdef A2_A2_INREG_EN
    a2_a2_opnd_t x_q;
    a2_a2_opnd_t y_q;
    logic        c0_q;

    // Both stages clear on the same reset edge, so the pipe restarts empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q  <= '0;
            y_q  <= '0;
            c0_q <= 1'b0;
        end else begin
            x_q  <= x;
            y_q  <= y;
            c0_q <= c0;
        end
    end

    assign op_a  = x_q;
    assign op_b  = y_q;
    assign op_ci = c0_q;
`else
    assign op_a  = x;
    assign op_b  = y;
    assign op_ci = c0;
`endif

    // k[i] is the carry into bit i; k[WIDTH] is the carry-out.
    logic [A2_A2_WIDTH:0]   k;
    logic [A2_A2_WIDTH-1:0] sum_bits;
    a2_a2_res_t             res;

    assign k[0] = op_ci;

    generate
        for (genvar i = 0; i < A2_A2_WIDTH; i++) begin : g_ripple
            a2_a2_fa u_fa (
                .a  (op_a[i]),
                .b  (op_b[i]),
                .ci (k[i]),
                .s  (sum_bits[i]),
                .co (k[i+1])
            );
        end
    endgenerate

    assign res = {k[A2_A2_WIDTH], sum_bits};

    a2_a2_res_t res_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res;
        end
    end

    assign s = res_q[A2_A2_WIDTH-1:0];
    assign c = res_q[A2_A2_WIDTH];

endmodule : a2_a2

// File: tb/tb_a2_a2.sv
// Self-checking bench for a2_a2: directed steps plus randomized traffic against
// an arithmetic reference model that tracks per-edge reset and operand history.
module tb_a2_a2;

`ifdef A2_A2_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] x = '0;
    logic [1:0] y = '0;
    logic       c0 = 1'b0;
    logic [1:0] s;
    logic       c;

    int total = 0;
    int bad   = 0;

    // One entry per rising edge: was reset asserted, and the true sum offered.
    int hist_rst[$];
    int hist_sum[$];

    a2_a2 dut (
        .s     (s),
        .c     (c),
        .x     (x),
        .y     (y),
        .c0    (c0),
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    // Output after the latest edge: zero if any of the last LAT edges saw reset,
    // otherwise the sum offered LAT-1 edges ago.
    function automatic logic [2:0] model_out();
        int n = hist_rst.size();
        if (n < LAT) return 3'd0;
        for (int k = 0; k < LAT; k++) begin
            if (hist_rst[n-1-k] != 0) return 3'd0;
        end
        return 3'(hist_sum[n-LAT]);
    endfunction

    task automatic check(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed {c,s}=%b expected %b", tag, observed, expected);
        end
    endtask

    task automatic step(input logic [1:0] xv, input logic [1:0] yv, input logic cv,
                        input logic rv, input string tag);
        @(negedge clk);
        x     = xv;
        y     = yv;
        c0    = cv;
        rst_n = rv;
        @(posedge clk);
        hist_rst.push_back(rv ? 0 : 1);
        hist_sum.push_back(int'(xv) + int'(yv) + int'(cv));
        #1;
        check(tag, {c, s}, model_out());
    endtask

    initial begin
        // Reset held for two edges with all-ones operands.
        step(2'd3, 2'd3, 1'b1, 1'b0, "reset_edge1");
        check("reset_zero1", {c, s}, 3'd0);
        step(2'd3, 2'd3, 1'b1, 1'b0, "reset_edge2");
        check("reset_zero2", {c, s}, 3'd0);

        // Exhaustive sweep: x every cycle, y every 4, c0 every 16, then flush.
        for (int i = 0; i < 32 + LAT; i++) begin
            logic [4:0] v;
            v = 5'(i % 32);
            step(v[1:0], v[3:2], v[4], 1'b1, "sweep");
        end

        // Boundary values, each held long enough to emerge from the pipe.
        for (int k = 0; k < LAT; k++) step(2'd3, 2'd3, 1'b1, 1'b1, "maximum");
        check("maximum_7", {c, s}, 3'd7);
        for (int k = 0; k < LAT; k++) step(2'd0, 2'd0, 1'b0, 1'b1, "minimum");
        check("minimum_0", {c, s}, 3'd0);
        for (int k = 0; k < LAT; k++) step(2'd1, 2'd2, 1'b1, 1'b1, "ripple");
        check("ripple_c1_s0", {c, s}, 3'b100);

        // Reset mid-operation for a single edge.
        for (int k = 0; k < LAT; k++) step(2'd2, 2'd1, 1'b0, 1'b1, "mid_run");
        check("mid_run_3", {c, s}, 3'd3);
        step(2'd2, 2'd1, 1'b0, 1'b0, "mid_reset");
        check("mid_reset_0", {c, s}, 3'd0);
        for (int k = 0; k < LAT; k++) step(2'd2, 2'd1, 1'b0, 1'b1, "post_reset");
        check("post_reset_3", {c, s}, 3'd3);

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 200; i++) begin
            step(2'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 15) != 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_a2_a2
